arbitro_soma: RTL

- Round-robin arbiter and sequencer that shares one 16-bit two's-complement adder (16-stage ripple-carry chain, overflow flag) between two requesters.
- Each requester has a valid/ready issue handshake, a registered one-cycle response pulse, and a private 16-bit accumulator for running-sum mode.
- Sits between the datapath control units and the single adder instance, so only one adder exists in the design.

---
 rtl/arbitro_soma.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/arbitro_soma.sv
// ---------------------------------------------------------------------------
// arbitro_soma
//   Round-robin arbiter that shares one 16-bit two's-complement ripple-carry
//   adder between two requesters. Each requester owns a private accumulator
//   for running-sum operations.
//
// Handshake: a requester raises validN with stable operands and holds them
//   until readyN is seen high. The operation is accepted in the cycle where
//   validN & readyN are both high. readyN is never raised without validN, and
//   at most one ready is high per cycle. The result appears one clock later
//   as a single-cycle rvalidN pulse, with sumN/ovfN held until the next
//   response to the same requester.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   validN, aN, bN           request and operands from requester N
//   accN                     use acc_qN as operand A and write the sum back
//   clrN                     clear acc_qN at the next edge
//   readyN                   grant to requester N (combinational)
//   rvalidN, sumN, ovfN      registered response to requester N
//   acc_q0, acc_q1           accumulator contents
// ---------------------------------------------------------------------------
module arbitro_soma #(
  parameter int WIDTH    = 16,
  parameter bit PTR_INIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             acc0,
  input  logic             clr0,
  output logic             ready0,
  output logic             rvalid0,
  output logic [WIDTH-1:0] sum0,
  output logic             ovf0,
  input  logic             valid1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             acc1,
  input  logic             clr1,
  output logic             ready1,
  output logic             rvalid1,
  output logic [WIDTH-1:0] sum1,
  output logic             ovf1,
  output logic [WIDTH-1:0] acc_q0,
  output logic [WIDTH-1:0] acc_q1
);

  // The adder is a fixed 16-bit instance; any other width is meaningless.
  if (WIDTH != 16) begin : g_bad_width
    $error("arbitro_soma: WIDTH must be 16");
  end

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic             ptr_q, ptr_d;        // requester holding priority
  logic             rvalid0_q, rvalid1_q;
  logic [WIDTH-1:0] sum0_q, sum1_q;
  logic             ovf0_q, ovf1_q;
  logic [WIDTH-1:0] acc0_q, acc1_q;

  // -------------------------------------------------------------------------
  // Grant: a lone requester always wins; on contention ptr decides.
  // Grants are held low during reset.
  // -------------------------------------------------------------------------
  logic gnt0, gnt1;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      gnt0 = valid0 && (!valid1 || (ptr_q == 1'b0));
      gnt1 = valid1 && (!valid0 || (ptr_q == 1'b1));
    end
  end

  // After a grant, priority passes to the other requester.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt0)      ptr_d = 1'b1;
    else if (gnt1) ptr_d = 1'b0;
  end

  // -------------------------------------------------------------------------
  // Operand mux. A clear in the same cycle as an accumulate op forces the
  // accumulator operand to zero so the result is 0 + b.
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] op_a, op_b;

  always_comb begin
    op_a = '0;
    op_b = '0;
    if (gnt0) begin
      op_a = acc0 ? (clr0 ? '0 : acc0_q) : a0;
      op_b = b0;
    end else if (gnt1) begin
      op_a = acc1 ? (clr1 ? '0 : acc1_q) : a1;
      op_b = b1;
    end
  end

  // -------------------------------------------------------------------------
  // Shared ripple-carry adder, carry-in tied to 0.
  // Signed overflow = carry into MSB xor carry out of MSB.
  // -------------------------------------------------------------------------
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] add_sum;
  logic             add_ovf;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign add_sum[i]  = op_a[i] ^ op_b[i] ^ carry[i];
    assign carry[i+1]  = (op_a[i] & op_b[i]) | (carry[i] & (op_a[i] ^ op_b[i]));
  end

  assign add_ovf = carry[WIDTH-1] ^ carry[WIDTH];

  // -------------------------------------------------------------------------
  // Sequential state
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= PTR_INIT;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      sum0_q    <= '0;
      sum1_q    <= '0;
      ovf0_q    <= 1'b0;
      ovf1_q    <= 1'b0;
      acc0_q    <= '0;
      acc1_q    <= '0;
    end else begin
      ptr_q     <= ptr_d;
      rvalid0_q <= gnt0;
      rvalid1_q <= gnt1;

      if (gnt0) begin
        sum0_q <= add_sum;
        ovf0_q <= add_ovf;
      end
      if (gnt1) begin
        sum1_q <= add_sum;
        ovf1_q <= add_ovf;
      end

      // Clear wins over a plain hold; a same-cycle accumulate stores 0 + b,
      // which the operand mux has already produced on add_sum.
      if (gnt0 && acc0)  acc0_q <= add_sum;
      else if (clr0)     acc0_q <= '0;

      if (gnt1 && acc1)  acc1_q <= add_sum;
      else if (clr1)     acc1_q <= '0;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign ready0  = gnt0;
  assign ready1  = gnt1;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign sum0    = sum0_q;
  assign sum1    = sum1_q;
  assign ovf0    = ovf0_q;
  assign ovf1    = ovf1_q;
  assign acc_q0  = acc0_q;
  assign acc_q1  = acc1_q;

endmodule
